// File: rtl/memif_arbiter_pkg.sv
// memif_pkg: shared types for the memory-interface arbiter
package memif_pkg;
    typedef enum logic {IDLE, WAIT} memif_arb_state_e;
    localparam int MEMIF_AW = 32;
    localparam int MEMIF_DW = 32;
    localparam int MEMIF_SW = MEMIF_DW / 8;
    typedef struct packed {
        logic [MEMIF_AW-1:0] addr;
        logic                we;
        logic [MEMIF_DW-1:0] wdata;
        logic [MEMIF_SW-1:0] strb;
    } memif_req_t;
    function automatic int tmo_width(int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction
endpackage

// File: rtl/memif_arbiter_if.sv
// memif_arbiter_if: initiator-side and target-side buses of the arbiter
interface memif_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                     req_mreq_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_maddr_i;
    logic [NUM_REQ-1:0]                     req_mwe_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_mwdata_i;
    logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   req_mstrb_i;
    logic [NUM_REQ-1:0]                     req_mack_o;
    logic [DATA_WIDTH-1:0]                  req_mrdata_o;
    logic                                   req_mresp_o;
    logic                                   mreq_o;
    logic [ADDR_WIDTH-1:0]                  maddr_o;
    logic                                   mwe_o;
    logic [DATA_WIDTH-1:0]                  mwdata_o;
    logic [DATA_WIDTH/8-1:0]                mstrb_o;
    logic                                   mack_i;
    logic [DATA_WIDTH-1:0]                  mrdata_i;
    logic                                   mresp_i;
    modport slave (
        input  req_mreq_i, req_maddr_i, req_mwe_i, req_mwdata_i, req_mstrb_i,
        input  mack_i, mrdata_i, mresp_i,
        output req_mack_o, req_mrdata_o, req_mresp_o,
        output mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o
    );
    modport master (
        output req_mreq_i, req_maddr_i, req_mwe_i, req_mwdata_i, req_mstrb_i,
        output mack_i, mrdata_i, mresp_i,
        input  req_mack_o, req_mrdata_o, req_mresp_o,
        input  mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o
    );
endinterface

// File: rtl/memif_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first pending bit at or after ptr
module rr_picker #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (pending[j]) idx = IW'(j);
        end
        // candidates at or after ptr override the wrapped-around choice
        for (int j = N - 1; j >= 0; j--) begin
            if (pending[j] && IW'(j) >= ptr) idx = IW'(j);
        end
        grant = (|pending) ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/memif_arbiter.sv
// memif_arbiter: round-robin sharing of one memory-interface target among NUM_REQ initiators
module memif_arbiter
    import memif_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic clk_i,
    input logic srst_i,
    memif_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = tmo_width(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    memif_arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d, pick_oh, ack;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick_idx, sel;
    logic [TW-1:0] tmo_q, tmo_d;
    logic tmo_hit, drive, mreq, done, fwd;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .pending(pending_q),
        .ptr(ptr_q),
        .grant(pick_oh),
        .idx(pick_idx)
    );

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tmo_d = '0;
        sel = grant_q;
        drive = 1'b0;
        mreq = 1'b0;
        done = 1'b0;
        fwd = 1'b0;
        if (state_q == IDLE) begin
            if (|pending_q) begin
                sel = pick_idx;
                grant_d = pick_idx;
                drive = 1'b1;
                mreq = 1'b1;
                done = bus.mack_i;
                fwd = bus.mack_i;
                state_d = bus.mack_i ? IDLE : WAIT;
            end
        end else begin
            drive = 1'b1;
            tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
            fwd = bus.mack_i;
            done = bus.mack_i || tmo_hit;
            if (done) begin
                state_d = IDLE;
                tmo_d = '0;
            end
        end
        ptr_d = done ? ((sel == LAST) ? '0 : sel + 1'b1) : ptr_q;
        ack = done ? (mreq ? pick_oh : (NUM_REQ'(1) << grant_q)) : '0;
        pending_d = (pending_q & ~ack) | bus.req_mreq_i;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            pending_q <= '0;
            ptr_q <= '0;
            grant_q <= '0;
            tmo_q <= '0;
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            tmo_q <= tmo_d;
        end
    end

    assign addr_mux = drive ? bus.req_maddr_i[sel] : '0;
    assign wdata_mux = drive ? bus.req_mwdata_i[sel] : '0;
    assign bus.mreq_o = mreq;
    assign bus.maddr_o = addr_mux;
    assign bus.mwe_o = drive && bus.req_mwe_i[sel];
    assign bus.mwdata_o = wdata_mux;
    assign bus.mstrb_o = drive ? bus.req_mstrb_i[sel] : '0;
    assign bus.req_mack_o = ack;
    // a completion that is not a forwarded target ack is a timeout: forced error, zero data
    assign bus.req_mrdata_o = fwd ? bus.mrdata_i : '0;
    assign bus.req_mresp_o = fwd ? bus.mresp_i : done;
endmodule

// File: doc/memif_arbiter.md
# memif_arbiter

Round-robin arbiter that shares one memory-interface target, such as a register file or FIFO block, between `NUM_REQ` memory-interface initiators, such as APB bridges or DMA ports. Each initiator uses the single-cycle-pulse request protocol: the `mreq` pulse is latched, and address, write data and strobe are held stable until acknowledged. The arbiter serializes requests toward the target, routes the response back to the winner, and enforces an optional response timeout. It sits between the initiator-side memory-interface adapters and the peripheral register block.

## Interface
- `NUM_REQ`, default 2: number of initiators, minimum 2.
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width, a multiple of 8.
- `TIMEOUT_CYCLES`, default 0: maximum WAIT cycles before a forced error response. 0 disables the timeout.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk_i` input 1: clock.
- `srst_i` input 1: synchronous reset, active-high.
- `req_mreq_i` input [NUM_REQ]: per-initiator request pulse.
- `req_maddr_i` input [NUM_REQ][ADDR_WIDTH]: address, held until ack.
- `req_mwe_i` input [NUM_REQ]: write enable.
- `req_mwdata_i` input [NUM_REQ][DATA_WIDTH]: write data.
- `req_mstrb_i` input [NUM_REQ][DATA_WIDTH/8]: byte strobe.
- `req_mack_o` output [NUM_REQ]: one-hot acknowledge, one cycle.
- `req_mrdata_o` output [DATA_WIDTH]: read data, broadcast to all initiators, valid with ack.
- `req_mresp_o` output 1: error flag, valid with ack.
- `mreq_o` output 1: target request pulse.
- `maddr_o` output [ADDR_WIDTH]: target address.
- `mwe_o` output 1: target write enable.
- `mwdata_o` output [DATA_WIDTH]: target write data.
- `mstrb_o` output [DATA_WIDTH/8]: target byte strobe.
- `mack_i` input 1: target acknowledge.
- `mrdata_i` input [DATA_WIDTH]: target read data.
- `mresp_i` input 1: target error.

## Operation
**Pending flags**
- `pending_q[i]` is set by `req_mreq_i[i]` and cleared when `req_mack_o[i]` is asserted.
- If set and clear occur in the same cycle, set wins.
- A pulse on an initiator that is already pending is absorbed; there is no double service.

**State machine: IDLE, WAIT**
- IDLE, `pending_q` = 0: all target outputs driven to 0.
- IDLE, `pending_q` ≠ 0: the winner is the first set bit at or after `ptr_q`, searching cyclically.
  - `mreq_o` = 1 combinationally in this cycle.
  - `maddr_o`/`mwe_o`/`mwdata_o`/`mstrb_o` are muxed from the winner.
  - `grant_q` ← winner.
  - If `mack_i` = 1 in the same cycle, the transaction completes: stay in IDLE.
  - Otherwise, go to WAIT.
- WAIT:
  - `mreq_o` = 0.
  - Address and data remain muxed from `grant_q`.
  - `tmo_q` increments each cycle.
- WAIT completion on `mack_i`:
  - `req_mack_o[grant_q]` = 1.
  - `req_mrdata_o` = `mrdata_i`.
  - `req_mresp_o` = `mresp_i`.
  - Go to IDLE.
- WAIT timeout, when `TIMEOUT_CYCLES` ≠ 0 and `tmo_q` = `TIMEOUT_CYCLES`-1 with no `mack_i`:
  - `req_mack_o[grant_q]` = 1.
  - `req_mrdata_o` = 0.
  - `req_mresp_o` = 1.
  - Go to IDLE.
- Late target ack: a `mack_i` arriving in IDLE with no request issued is ignored.

**Pointer and counter**
- On every completion, `ptr_q` ← (winner + 1) mod `NUM_REQ`.
- `tmo_q` is cleared on entering IDLE.
- `tmo_q` width is $clog2(`TIMEOUT_CYCLES`+1), minimum 1.
- `tmo_q` saturates and never wraps.

**Idle outputs**
- When no ack is asserted, `req_mrdata_o` = 0 and `req_mresp_o` = 0.

**Reset**
- `srst_i` mid-transaction: state ← IDLE, `pending_q` ← 0, `ptr_q` ← 0, `grant_q` ← 0, `tmo_q` ← 0.
- The in-flight initiator receives no ack.
- All outputs read 0 in the cycle after the reset edge and stay 0 while reset is held.

## Timing
- Request at cycle N, target acks combinationally: `mreq_o` at N+1, `req_mack_o` at N+1. Minimum latency is 1 cycle.
- Target acks k cycles after `mreq_o`: `req_mack_o` is asserted in that same ack cycle.
- No registered delay on the response path.
- Back-to-back transactions:
  - After a completion, the next `mreq_o` can issue in the following cycle.
  - Maximum throughput is one transaction per cycle with a combinational target.
- The request mux toward the target is combinational from `pending_q`, `ptr_q` and the input fields. No input-to-`mreq_o` combinational path exists except through `pending_q`.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after the `mreq_o` cycle.

## Structure
- Package `memif_pkg` provides:
  - `memif_arb_state_e` (IDLE, WAIT).
  - The `memif_req_t` struct (addr, we, wdata, strb), parameterized through localparam widths.
- Sub-module `rr_picker` is purely combinational: it takes the `pending` vector and `ptr`, and returns a one-hot grant plus its index.
- The top level holds the FSM, `pending_q`, `ptr_q`, `grant_q`, `tmo_q` and the muxes.

## Test plan
- Single initiator 0 reads 0x10, target acks at once with 0xDEADBEEF:
  - `mreq_o` one cycle after the request.
  - `req_mack_o` = 2'b01 in that same cycle.
  - `req_mrdata_o` = 0xDEADBEEF.
- Both initiators pulse in the same cycle, `ptr_q` = 0, target acks after 2 cycles each:
  - Service order is 0 then 1.
  - A second simultaneous pair is served in order 0 then 1 again (`ptr_q` back at 0 after serving 1).
- Initiator 1 writes 0xA5 with strobe 4'b0001 while initiator 0 is in WAIT:
  - Initiator 1 pends.
  - Its `mreq_o` issues the cycle after initiator 0's ack.
  - `mwdata_o` = 0xA5, `mstrb_o` = 1.
- `TIMEOUT_CYCLES` = 4, target never acks:
  - `req_mack_o` asserted 4 cycles after `mreq_o`, with `req_mresp_o` = 1 and `req_mrdata_o` = 0.
  - A later `mack_i` is ignored.
- Target returns `mresp_i` = 1: the error is forwarded on `req_mresp_o` with the ack.
- `srst_i` asserted during WAIT:
  - All outputs are 0 the next cycle.
  - A pending request from the other initiator is dropped.
  - The next fresh pulse is served normally.
